// File: rtl/l1b_event_capture_pkg.sv
// Shared types and constants for the L1 buffer event capture block.
package l1b_pkg;

  localparam int unsigned L1B_DATA_WIDTH = 272;
  localparam int unsigned CH_WIDTH       = 264;
  localparam int unsigned L0ID_WIDTH     = 8;

  // Hit reduction modes over the (BC-1, BC, BC+1) word triplet
  typedef enum logic [1:0] {
    HitMid  = 2'd0,  // X1X
    HitRise = 2'd1,  // 01X
    HitAny  = 2'd2,  // 1XX | X1X | XX1
    HitAll  = 2'd3   // XXX, forces all ones
  } hit_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCap1 = 2'd1,
    StCap2 = 2'd2
  } state_e;

  localparam logic EvR3 = 1'b0;
  localparam logic EvL1 = 1'b1;

  typedef struct packed {
    logic                  ev_type;
    logic                  seq_err;
    logic [L0ID_WIDTH-1:0] l0id;
    logic [CH_WIDTH-1:0]   hits;
  } event_t;

  localparam int unsigned EVENT_WIDTH = $bits(event_t);

  // Per-channel hit mask from previous, current and next BC words
  function automatic logic [CH_WIDTH-1:0] hit_reduce(input hit_mode_e           mode,
                                                     input logic [CH_WIDTH-1:0] p,
                                                     input logic [CH_WIDTH-1:0] c,
                                                     input logic [CH_WIDTH-1:0] n);
    logic [CH_WIDTH-1:0] h;
    unique case (mode)
      HitMid:  h = c;
      HitRise: h = ~p & c;
      HitAny:  h = p | c | n;
      HitAll:  h = '1;
      default: h = c;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/l1b_event_capture_if.sv
// Readout input bus and event output handshake of the capture block.
interface l1b_event_capture_if;

  logic                               L1B_Read_R3;
  logic                               L1B_Read_L1;
  logic [l1b_pkg::L1B_DATA_WIDTH-1:0] L1B_DataOut;
  logic                               Ev_Valid;
  logic                               Ev_Ready;
  logic                               Ev_Type;
  logic [l1b_pkg::L0ID_WIDTH-1:0]     Ev_L0ID;
  logic                               Ev_SeqErr;
  logic [l1b_pkg::CH_WIDTH-1:0]       Ev_Hits;

  // Environment side: drives readout and consumer ready
  modport master (
    output L1B_Read_R3, L1B_Read_L1, L1B_DataOut, Ev_Ready,
    input  Ev_Valid, Ev_Type, Ev_L0ID, Ev_SeqErr, Ev_Hits
  );

  // Capture block side
  modport slave (
    input  L1B_Read_R3, L1B_Read_L1, L1B_DataOut, Ev_Ready,
    output Ev_Valid, Ev_Type, Ev_L0ID, Ev_SeqErr, Ev_Hits
  );

endinterface

// File: rtl/l1b_event_capture_evt_fifo.sv
// First-word-fall-through event FIFO with occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module evt_fifo #(
  parameter  int unsigned Width = 8,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned LvlW  = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [Width-1:0] rdata,
  output logic [LvlW-1:0]  level
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LvlW'(Depth));
  assign valid   = (level_q != '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & valid;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  // Storage, pointers (wrap naturally, Depth is a power of two) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end
  end

endmodule

// File: rtl/l1b_event_capture.sv
// L1 buffer readout capture: collects 3-word bursts, checks L0ID sequencing,
// reduces the triplet to a hit mask and queues events for the cluster finder.
module l1b_event_capture #(
  parameter int unsigned DATA_WIDTH = 264,
  parameter int unsigned L0ID_WIDTH = 8,
  parameter int unsigned EVT_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                         CLK,
  input  logic                         SoftReset,
  l1b_event_capture_if.slave           bus,
  input  logic [1:0]                   HitMode,
  output logic [$clog2(EVT_DEPTH):0]   Fifo_Level,
  output logic [CNT_WIDTH-1:0]         Overflow_Cnt,
  output logic [CNT_WIDTH-1:0]         Trunc_Cnt,
  output logic                         Collision
);

  import l1b_pkg::*;

  localparam int unsigned WordW = DATA_WIDTH + L0ID_WIDTH;

  state_e                state_q, state_d;
  logic                  type_q, type_d;
  hit_mode_e             mode_q, mode_d;
  logic [WordW-1:0]      w0_q, w0_d;
  logic [WordW-1:0]      w1_q, w1_d;
  logic                  commit, abort;
  logic                  r3, l1, own;
  logic [L0ID_WIDTH-1:0] id0, id1, id2;
  event_t                ev_new, ev_head;
  logic                  fifo_full, fifo_valid, pop;
  logic [CNT_WIDTH-1:0]  ovf_q, trunc_q;
  logic                  coll_q;

  assign r3  = bus.L1B_Read_R3;
  assign l1  = bus.L1B_Read_L1;
  // Only the strobe of the latched burst type keeps a burst alive
  assign own = (type_q == EvL1) ? l1 : r3;

  // Burst capture FSM: registers
  always_ff @(posedge CLK or posedge SoftReset) begin
    if (SoftReset) begin
      state_q <= StIdle;
      type_q  <= EvR3;
      mode_q  <= HitMid;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      mode_q  <= mode_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  // Burst capture FSM: next state, word capture, commit/abort decode
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    mode_d  = mode_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    commit  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (r3 | l1) begin
          w0_d    = bus.L1B_DataOut;
          type_d  = r3 ? EvR3 : EvL1;
          mode_d  = hit_mode_e'(HitMode);
          state_d = StCap1;
        end
      end
      StCap1: begin
        if (own) begin
          w1_d    = bus.L1B_DataOut;
          state_d = StCap2;
        end else begin
          abort   = 1'b1;
          state_d = StIdle;
        end
      end
      StCap2: begin
        state_d = StIdle;
        if (own) commit = 1'b1;
        else     abort  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Event assembly; the third word is used straight from the bus
  always_comb begin
    id0             = w0_q[DATA_WIDTH +: L0ID_WIDTH];
    id1             = w1_q[DATA_WIDTH +: L0ID_WIDTH];
    id2             = bus.L1B_DataOut[DATA_WIDTH +: L0ID_WIDTH];
    ev_new          = '0;
    ev_new.ev_type  = type_q;
    ev_new.l0id     = id1;
    ev_new.seq_err  = (id1 != id0 + L0ID_WIDTH'(1)) | (id2 != id1 + L0ID_WIDTH'(1));
    ev_new.hits     = hit_reduce(mode_q, w0_q[DATA_WIDTH-1:0], w1_q[DATA_WIDTH-1:0],
                                 bus.L1B_DataOut[DATA_WIDTH-1:0]);
  end

  assign pop = fifo_valid & bus.Ev_Ready;

  evt_fifo #(
    .Width (EVENT_WIDTH),
    .Depth (EVT_DEPTH)
  ) u_evt_fifo (
    .clk   (CLK),
    .rst   (SoftReset),
    .push  (commit),
    .wdata (ev_new),
    .pop   (pop),
    .full  (fifo_full),
    .valid (fifo_valid),
    .rdata (ev_head),
    .level (Fifo_Level)
  );

  // Saturating status counters and sticky strobe collision flag
  always_ff @(posedge CLK or posedge SoftReset) begin
    if (SoftReset) begin
      ovf_q   <= '0;
      trunc_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      if (commit && fifo_full && !pop && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
      if (abort && trunc_q != '1) trunc_q <= trunc_q + 1'b1;
      if (r3 && l1) coll_q <= 1'b1;
    end
  end

  assign Overflow_Cnt  = ovf_q;
  assign Trunc_Cnt     = trunc_q;
  assign Collision     = coll_q;
  assign bus.Ev_Valid  = fifo_valid;
  assign bus.Ev_Type   = ev_head.ev_type;
  assign bus.Ev_L0ID   = ev_head.l0id;
  assign bus.Ev_SeqErr = ev_head.seq_err;
  assign bus.Ev_Hits   = ev_head.hits;

endmodule
